gpio_cmd_master: RTL

//  Initiator side of the 32-bit GPIO command protocol. The DSP register file is the responder.

---
 rtl/gpio_cmd_pkg.sv | 37 +++
 rtl/gpio_cmd_if.sv | 30 +++
 rtl/gpio_cmd_phase.sv | 65 ++++++
 rtl/gpio_cmd_master.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gpio_cmd_pkg.sv
// rtl/gpio_cmd_pkg.sv - field widths, opcode constants and request encoding for the GPIO command master
//  Contents: word/field widths, op-type constants, register and count-log codes,
//  req_kind encoding, read_opcode() helper.
package gpio_cmd_pkg;

  localparam int GPIO_LEN    = 32;
  localparam int OPCODE_LEN  = 8;
  localparam int OP_TYPE_LEN = 2;
  localparam int CODE_LEN    = OPCODE_LEN - OP_TYPE_LEN;
  localparam int DATA_LEN    = GPIO_LEN - OPCODE_LEN - 1;
  localparam int EN_BIT      = DATA_LEN;

  localparam logic [OP_TYPE_LEN-1:0] OP_REG       = 2'b00;
  localparam logic [OP_TYPE_LEN-1:0] OP_COUNT_LOG = 2'b10;
  localparam logic [OP_TYPE_LEN-1:0] OP_MEM_LOG   = 2'b11;

  localparam logic [CODE_LEN-1:0] REG_RESET   = 6'h00;
  localparam logic [CODE_LEN-1:0] REG_ENABLE  = 6'h01;
  localparam logic [CODE_LEN-1:0] REG_PHASE   = 6'h02;
  // Count-log codes 0x00-0x07 are {counter idx, lo}; 0x08 snapshots all counters.
  localparam logic [CODE_LEN-1:0] CL_CNT_BASE = 6'h00;
  localparam logic [CODE_LEN-1:0] CL_LATCH    = 6'h08;
  localparam logic [CODE_LEN-1:0] MAX_READ_IDX = 6'd3;

  typedef enum logic [1:0] {
    KIND_WRITE = 2'b00,
    KIND_LATCH = 2'b01,
    KIND_READ  = 2'b10,
    KIND_RSVD  = 2'b11
  } req_kind_e;

  // Counter idx i: high word at code 2i, low word at code 2i+1.
  function automatic logic [OPCODE_LEN-1:0] read_opcode(input logic [1:0] idx, input logic lo);
    return {OP_COUNT_LOG, CL_CNT_BASE + {3'b000, idx, lo}};
  endfunction

endpackage

// File: rtl/gpio_cmd_if.sv
// rtl/gpio_cmd_if.sv - request/response and GPIO word bundle for gpio_cmd_master
//  Request : req_valid, req_ready, req_kind[1:0], req_code[5:0], req_data[22:0]
//  Response: rsp_valid, rsp_err, rsp_data[63:0]
//  GPIO    : gpio_out[31:0] (to register file), gpio_in[31:0] (from register file)
//  Modports: master = command initiator, slave = requester plus responder side.
interface gpio_cmd_if;
  import gpio_cmd_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_kind;
  logic [CODE_LEN-1:0]  req_code;
  logic [DATA_LEN-1:0]  req_data;
  logic                 rsp_valid;
  logic                 rsp_err;
  logic [63:0]          rsp_data;
  logic [GPIO_LEN-1:0]  gpio_out;
  logic [GPIO_LEN-1:0]  gpio_in;

  modport master (
    input  req_valid, req_kind, req_code, req_data, gpio_in,
    output req_ready, rsp_valid, rsp_err, rsp_data, gpio_out
  );

  modport slave (
    output req_valid, req_kind, req_code, req_data, gpio_in,
    input  req_ready, rsp_valid, rsp_err, rsp_data, gpio_out
  );

endinterface

// File: rtl/gpio_cmd_phase.sv
// rtl/gpio_cmd_phase.sv - drives one command word through pulse and settle, flags the capture cycle
//  Ports: clk, rst (async, active-low), start (load word, begin pulse), opcode, data,
//  gpio_in (responder word), gpio_out (command word), done (last settle cycle),
//  cap_word (responder word to store on done).
module gpio_cmd_phase
  import gpio_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OPCODE_LEN-1:0] opcode,
  input  logic [DATA_LEN-1:0]   data,
  input  logic [GPIO_LEN-1:0]   gpio_in,
  output logic [GPIO_LEN-1:0]   gpio_out,
  output logic                  done,
  output logic [GPIO_LEN-1:0]   cap_word
);

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_PULSE  = 2'd1;
  localparam logic [1:0] PH_SETTLE = 2'd2;

  localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  logic [1:0]  st;
  logic [15:0] cnt;

  // Start may coincide with done of the previous word; the new word wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= PH_IDLE;
      cnt      <= '0;
      gpio_out <= '0;
    end else if (start) begin
      st       <= PH_PULSE;
      cnt      <= '0;
      gpio_out <= {opcode, 1'b1, data};
    end else begin
      case (st)
        PH_PULSE: begin
          if (cnt == PULSE_LAST) begin
            st               <= PH_SETTLE;
            cnt              <= '0;
            gpio_out[EN_BIT] <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PH_SETTLE: begin
          if (cnt == SETTLE_LAST) st <= PH_IDLE;
          else                    cnt <= cnt + 16'd1;
        end
        default: st <= PH_IDLE;
      endcase
    end
  end

  assign done     = (st == PH_SETTLE) && (cnt == SETTLE_LAST);
  assign cap_word = gpio_in;

endmodule

// File: rtl/gpio_cmd_master.sv
// rtl/gpio_cmd_master.sv - turns one request into a sequence of GPIO command words and one response
//  Ports: clk, rst (async, active-low), bus (gpio_cmd_if.master: request, response, gpio_out/gpio_in).
//  Parameters: PULSE_CYCLES (enable-high cycles per word), SETTLE_CYCLES (enable-low cycles per word).
//  Build option: GPIO_CMD_AUTO_LATCH_EN prefixes every counter read with a latch word.
module gpio_cmd_master #(
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  gpio_cmd_if.master  bus
);
  import gpio_cmd_pkg::*;

`ifdef GPIO_CMD_AUTO_LATCH_EN
  localparam logic LATCH_FIRST = 1'b1;
`else
  localparam logic LATCH_FIRST = 1'b0;
`endif
  localparam logic [1:0] HI_STEP   = LATCH_FIRST ? 2'd1 : 2'd0;
  localparam logic [1:0] READ_LAST = LATCH_FIRST ? 2'd2 : 2'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]           st;
  logic [1:0]           kind_r;
  logic [CODE_LEN-1:0]  code_r;
  logic [DATA_LEN-1:0]  data_r;
  logic [1:0]           step;
  logic [GPIO_LEN-1:0]  hi;
  logic                 rsp_valid_r, rsp_err_r;
  logic [63:0]          rsp_data_r;

  logic                 idle, accept, bad_req, last_step, start, done;
  logic [1:0]           cur_kind, next_step;
  logic [CODE_LEN-1:0]  cur_code;
  logic [DATA_LEN-1:0]  cur_data;
  logic [OPCODE_LEN-1:0] op;
  logic [DATA_LEN-1:0]  word_data;
  logic [GPIO_LEN-1:0]  cap_word;

  assign idle          = (st == ST_IDLE);
  assign bus.req_ready = idle;
  assign accept        = idle && bus.req_valid;

  always_comb begin
    bad_req = 1'b0;
    case (req_kind_e'(bus.req_kind))
      KIND_WRITE: bad_req = (bus.req_code > REG_PHASE);
      KIND_READ:  bad_req = (bus.req_code > MAX_READ_IDX);
      KIND_LATCH: bad_req = 1'b0;
      default:    bad_req = 1'b1;
    endcase
  end

  // The first word is loaded at the accept edge, so it is built from the live
  // request; later words come from the registered copy.
  assign cur_kind  = idle ? bus.req_kind : kind_r;
  assign cur_code  = idle ? bus.req_code : code_r;
  assign cur_data  = idle ? bus.req_data : data_r;
  assign next_step = idle ? 2'd0 : step + 2'd1;

  always_comb begin
    op        = {OP_COUNT_LOG, CL_LATCH};
    word_data = '0;
    case (req_kind_e'(cur_kind))
      KIND_WRITE: begin
        op        = {OP_REG, cur_code};
        word_data = cur_data;
      end
      KIND_READ: begin
        if (!(LATCH_FIRST && next_step == 2'd0))
          op = read_opcode(cur_code[1:0], next_step != HI_STEP);
      end
      default: ;
    endcase
  end

  assign last_step = (kind_r == KIND_READ) ? (step == READ_LAST) : 1'b1;
  assign start     = (accept && !bad_req) || ((st == ST_BUSY) && done && !last_step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= ST_IDLE;
      kind_r      <= '0;
      code_r      <= '0;
      data_r      <= '0;
      step        <= '0;
      hi          <= '0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (accept) begin
            kind_r <= bus.req_kind;
            code_r <= bus.req_code;
            data_r <= bus.req_data;
            step   <= '0;
            if (bad_req) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= '0;
              st          <= ST_RESP;
            end else begin
              st <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (done) begin
            if (step == HI_STEP) hi <= cap_word;
            if (last_step) begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= (kind_r == KIND_READ) ? {hi, cap_word} : 64'd0;
              st          <= ST_RESP;
            end else begin
              step <= step + 2'd1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;

  gpio_cmd_phase #(
    .PULSE_CYCLES  (PULSE_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (op),
    .data     (word_data),
    .gpio_in  (bus.gpio_in),
    .gpio_out (bus.gpio_out),
    .done     (done),
    .cap_word (cap_word)
  );

endmodule
